// File: rtl/branch_sequencer_if.sv
// Fetch/branch bus between the branch sequencer, execute-stage branch logic and instruction memory.
interface branch_sequencer_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              stall;
    logic              br_valid;
    logic              branch;
    logic [31:0]       branch_address;
    logic              halt_req;
    logic              imem_ready;
    logic              imem_req;
    logic [ADDR_W-1:0] pc;
    logic              flush;
    logic              halted;
    logic [15:0]       taken_cnt;

    modport master (
        input  stall, br_valid, branch, branch_address, halt_req, imem_ready,
        output imem_req, pc, flush, halted, taken_cnt
    );

    modport slave (
        output stall, br_valid, branch, branch_address, halt_req, imem_ready,
        input  imem_req, pc, flush, halted, taken_cnt
    );
endinterface

// File: rtl/branch_sequencer.sv
// MJ32 program counter and fetch sequencer: sequential fetch, taken-branch redirect with
// timed flush, halt handling and a saturating taken-branch counter.
module branch_sequencer #(
    parameter int unsigned ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    branch_sequencer_if.master  bus
);
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned TAKEN_W = 16;
    localparam logic [TAKEN_W-1:0] TAKEN_MAX = '1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_HALT
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                flush_q, flush_d;
    logic                halted_q, halted_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TAKEN_W-1:0]  taken_q, taken_d;
    logic                imem_req_c;
    logic                handshake_c;
    logic                taken_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
            taken_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            flush_q  <= flush_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
            taken_q  <= taken_d;
        end
    end

    // Next-state: branch redirect beats halt, halt beats sequential advance.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        flush_d     = flush_q;
        halted_d    = halted_q;
        cnt_d       = cnt_q;
        taken_d     = taken_q;
        imem_req_c  = (state_q != ST_HALT) && !bus.stall;
        handshake_c = imem_req_c && bus.imem_ready;
        taken_c     = bus.br_valid && bus.branch;

        case (state_q)
            ST_RUN: begin
                if (taken_c) begin
                    state_d = ST_FLUSH;
                    pc_d    = bus.branch_address[ADDR_W-1:0];
                    flush_d = 1'b1;
                    cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                    taken_d = (taken_q == TAKEN_MAX) ? taken_q : taken_q + TAKEN_W'(1);
                end else if (bus.halt_req) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else if (handshake_c) begin
                    pc_d = pc_q + ADDR_W'(1);
                end
            end
            ST_FLUSH: begin
                // Branch/halt inputs here belong to squashed instructions.
                flush_d = 1'b1;
                if (handshake_c) begin
                    pc_d = pc_q + ADDR_W'(1);
                end
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                    flush_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HALT: begin
                halted_d = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign bus.imem_req  = imem_req_c;
    assign bus.pc        = pc_q;
    assign bus.flush     = flush_q;
    assign bus.halted    = halted_q;
    assign bus.taken_cnt = taken_q;
endmodule
